// File: rtl/clk_rst_seq_pkg.sv
// rtl/clk_rst_seq_pkg.sv - shared types and widths for the clock/reset sequencer
//
// Contents:
//   seq_state_e : sequencer FSM states (encoding is visible on seq_state)
//   CNT_W       : width of the shared phase timer
//   LOSS_CNT_W  : width of the saturating lock-loss counter
package clk_rst_seq_pkg;

    localparam int CNT_W      = 16;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_RST    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/clk_rst_seq_sync2.sv
// rtl/clk_rst_seq_sync2.sv - two-flop synchronizer, async active-low reset to 0
//
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output, two clk edges of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - PLL-lock qualified divider/system reset sequencer
//
// Optional feature: define CLK_RST_SEQ_LOSS_CNT_EN to build the saturating
// lock-loss counter; otherwise lock_loss_cnt is tied to 0.
//
// Parameters:
//   LOCK_FILTER : consecutive synchronized lock-high cycles before divider release
//   DIV_SETTLE  : cycles from divider release to system reset release
//   SYS_HOLD    : cycles sys_rstn is held low for a software reset
// Ports:
//   hclkin        : only clock
//   resetn        : asynchronous active-low reset
//   pll_lock      : raw PLL lock, asynchronous
//   sw_rst_req    : single-cycle software reset request (honoured in RUN only)
//   div_resetn    : divider reset, high in SETTLE/RUN/SW_RST
//   sys_rstn      : system reset, high in RUN
//   seq_ready     : high in RUN
//   seq_state     : current FSM state (debug)
//   lock_loss_cnt : saturating count of lock-loss events
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int LOCK_FILTER = 16,
    parameter int DIV_SETTLE  = 64,
    parameter int SYS_HOLD    = 32
) (
    input  logic       hclkin,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       sw_rst_req,
    output logic       div_resetn,
    output logic       sys_rstn,
    output logic       seq_ready,
    output logic [2:0] seq_state,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DIV_SETTLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(SYS_HOLD - 1);

    logic lock_s;

    sync2 u_lock_sync (
        .clk   (hclkin),
        .rst_n (resetn),
        .d     (pll_lock),
        .q     (lock_s)
    );

    seq_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             div_resetn_d, div_resetn_q;
    logic             sys_rstn_d, sys_rstn_q;
    logic             seq_ready_d, seq_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                // Any low sample restarts the filter from zero.
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss outranks a coincident software request.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (sw_rst_req) begin
                    state_d = ST_SW_RST;
                    cnt_d   = '0;
                end
            end
            ST_SW_RST: begin
                // Further requests here are ignored, so the hold is not extended.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state change.
    always_comb begin
        div_resetn_d = (state_d == ST_SETTLE) || (state_d == ST_RUN) || (state_d == ST_SW_RST);
        sys_rstn_d   = (state_d == ST_RUN);
        seq_ready_d  = (state_d == ST_RUN);
    end

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            div_resetn_q <= 1'b0;
            sys_rstn_q   <= 1'b0;
            seq_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_resetn_q <= div_resetn_d;
            sys_rstn_q   <= sys_rstn_d;
            seq_ready_q  <= seq_ready_d;
        end
    end

    assign div_resetn = div_resetn_q;
    assign sys_rstn   = sys_rstn_q;
    assign seq_ready  = seq_ready_q;
    assign seq_state  = state_q;

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    logic                  loss_event;
    logic [LOSS_CNT_W-1:0] loss_cnt_d, loss_cnt_q;

    always_comb begin
        loss_event = !lock_s &&
                     ((state_q == ST_SETTLE) || (state_q == ST_RUN) || (state_q == ST_SW_RST));
        loss_cnt_d = loss_cnt_q;
        if (loss_event && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - randomized, model-checked bench for clk_rst_seq
module tb_clk_rst_seq;

    localparam int LOCK_FILTER = 16;
    localparam int DIV_SETTLE  = 64;
    localparam int SYS_HOLD    = 32;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       div_resetn, sys_rstn, seq_ready;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_rst_seq #(
        .LOCK_FILTER (LOCK_FILTER),
        .DIV_SETTLE  (DIV_SETTLE),
        .SYS_HOLD    (SYS_HOLD)
    ) dut (
        .hclkin        (clk),
        .resetn        (resetn),
        .pll_lock      (pll_lock),
        .sw_rst_req    (sw_rst_req),
        .div_resetn    (div_resetn),
        .sys_rstn      (sys_rstn),
        .seq_ready     (seq_ready),
        .seq_state     (seq_state),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase number, time spent in phase, run of good lock
    // samples, and a two-entry history standing in for synchronizer delay.
    int phase, since, run, losses, edge_no;
    bit hist1, hist2;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase = 0; since = 0; run = 0; losses = 0; edge_no = 0;
            hist1 = 0; hist2 = 0;
        end else begin
            bit ls;
            bit lost;
            edge_no++;
            ls    = hist2;
            hist2 = hist1;
            hist1 = pll_lock;
            lost  = (phase >= 2) && !ls;
            if (lost) begin
                phase = 1; since = 0; run = 0;
                if (losses < 255) losses++;
            end else begin
                case (phase)
                    0: begin phase = 1; run = 0; end
                    1: begin
                        run = ls ? run + 1 : 0;
                        if (run == LOCK_FILTER) begin phase = 2; since = 0; end
                    end
                    2: begin
                        since++;
                        if (since == DIV_SETTLE) begin phase = 3; since = 0; end
                    end
                    3: if (sw_rst_req) begin phase = 4; since = 0; end
                    4: begin
                        since++;
                        if (since == SYS_HOLD) begin phase = 3; since = 0; end
                    end
                    default: phase = 1;
                endcase
            end
        end
    end

    function automatic int exp_loss();
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
        return losses;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        chk("state",      int'(seq_state),  phase);
        chk("div_resetn", int'(div_resetn), int'(phase >= 2));
        chk("sys_rstn",   int'(sys_rstn),   int'(phase == 3));
        chk("seq_ready",  int'(seq_ready),  int'(phase == 3));
        chk("loss_cnt",   int'(lock_loss_cnt), exp_loss());
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic wait_div(output int at);
        at = -1;
        for (int i = 0; i < 400 && at < 0; i++) begin
            step();
            if (div_resetn) at = edge_no;
        end
    endtask

    task automatic wait_run();
        for (int i = 0; i < 400 && seq_state != 3'd3; i++) step();
        chk("reach_run", int'(seq_state), 3);
    endtask

    initial begin
        int at, low_cycles, lowleft;

        // Reset values while resetn is held low.
        #3;
        chk("rst_div", int'(div_resetn), 0);
        chk("rst_sys", int'(sys_rstn), 0);
        chk("rst_state", int'(seq_state), 0);

        // Lock stable from reset: divider after edge 18, system after edge 82.
        pll_lock = 1'b1;
        do_reset();
        wait_div(at);
        chk("div_rise_edge", at, 18);
        at = -1;
        for (int i = 0; i < 200 && at < 0; i++) begin
            step();
            if (sys_rstn) at = edge_no;
        end
        chk("sys_rise_edge", at, 82);
        chk("run_state", int'(seq_state), 3);
        chk("run_ready", int'(seq_ready), 1);

        // Software reset: sys_rstn low for exactly SYS_HOLD cycles.
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 200 && !sys_rstn; i++) begin
            low_cycles++;
            step();
        end
        chk("sw_hold_len", low_cycles, 32);

        // Lock glitch during WAIT_LOCK restarts the filter.
        pll_lock = 1'b0;
        do_reset();
        repeat (3) step();
        pll_lock = 1'b1;
        repeat (10) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        begin
            int rise_edge;
            rise_edge = edge_no + 1;
            wait_div(at);
            chk("glitch_div_edge", at, rise_edge + 17);
        end

        // Lock drop coinciding with the software request.
        pll_lock = 1'b1;
        do_reset();
        wait_run();
        pll_lock = 1'b0;
        step();
        step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        chk("coinc_state", int'(seq_state), 1);
        chk("coinc_div", int'(div_resetn), 0);
        chk("coinc_sys", int'(sys_rstn), 0);
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
        chk("coinc_loss", int'(lock_loss_cnt), 1);
`else
        chk("coinc_loss", int'(lock_loss_cnt), 0);
`endif

        // Asynchronous reset mid-SETTLE, then the full sequence restarts.
        pll_lock = 1'b1;
        for (int i = 0; i < 200 && seq_state != 3'd2; i++) step();
        repeat (5) step();
        chk("pre_async_state", int'(seq_state), 2);
        resetn = 1'b0;
        #1;
        chk("async_div", int'(div_resetn), 0);
        chk("async_sys", int'(sys_rstn), 0);
        chk("async_state", int'(seq_state), 0);
        step();
        resetn = 1'b1;
        wait_div(at);
        chk("restart_div_edge", at, 18);

        // Randomized lock drops and software requests.
        lowleft = 0;
        for (int i = 0; i < 4000; i++) begin
            if (lowleft > 0) begin
                lowleft--;
                pll_lock = (lowleft == 0);
            end else if ($urandom_range(149) == 0) begin
                lowleft  = $urandom_range(20, 1);
                pll_lock = 1'b0;
            end
            sw_rst_req = ($urandom_range(19) == 0);
            step();
        end
        sw_rst_req = 1'b0;
        pll_lock   = 1'b1;

        // 300 lock drops from SETTLE: counter saturates (or stays 0).
        do_reset();
        for (int n = 0; n < 300; n++) begin
            pll_lock = 1'b1;
            for (int i = 0; i < 100 && seq_state != 3'd2; i++) step();
            pll_lock = 1'b0;
            repeat (3) step();
        end
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
        chk("loss_saturate", int'(lock_loss_cnt), 255);
`else
        chk("loss_disabled", int'(lock_loss_cnt), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
